alu_wide_op_sequencer: RTL and testbench

Sequencer that drives the Width-bit SIMD ALU slice. It accepts one wide operation (SLICES × Width bits per operand) over a valid/ready handshake and decodes the opcode into ALU control fields. It issues the operands to the ALU one Width-bit slice per cycle, least significant slice first, and feeds each slice's carry-outs back as the next slice's carry-ins. It collects the returned S slices into a wide result with a valid/ready output handshake. It sits between the DSP-block control path and the combinational ALU.

---
 rtl/alu_wide_op_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_alu_wide_op_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_op_sequencer.sv
// Feeds a wide operation through the Width-bit ALU slice, LS slice first, chaining carries.
// Latency SLICES cycles from accept to out_valid; in_ready held low until the result is consumed.
module alu_wide_op_sequencer #(
  parameter int Width  = 8,
  parameter int SLICES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_opcode,
  input  logic [Width*SLICES-1:0]   in_W,
  input  logic [Width*SLICES-1:0]   in_X,
  input  logic [Width*SLICES-1:0]   in_Y,
  input  logic [Width*SLICES-1:0]   in_Z,
  output logic [Width-1:0]          alu_W,
  output logic [Width-1:0]          alu_X,
  output logic [Width-1:0]          alu_Y,
  output logic [Width-1:0]          alu_Z,
  output logic [1:0]                alu_op,
  output logic                      alu_Z_controller,
  output logic                      alu_S_controller,
  output logic                      alu_W_X_Y_controller,
  output logic [1:0]                alu_CIN_W_X_Y_CIN,
  output logic                      alu_CIN_Z_W_X_Y_CIN,
  input  logic [Width-1:0]          alu_S,
  input  logic [1:0]                alu_COUT_W_X_Y_CIN,
  input  logic                      alu_COUT_Z_W_X_Y_CIN,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [Width*SLICES-1:0]   out_result,
  output logic [2:0]                out_carry
);

  localparam int TOTAL = Width * SLICES;
  localparam int KW    = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [TOTAL-1:0]  w_q, w_d, x_q, x_d, y_q, y_d, z_q, z_d;
  logic [TOTAL-1:0]  res_q, res_d;
  logic [1:0]        c1_q, c1_d;
  logic              c2_q, c2_d;
  logic [Width-1:0]  alu_w_q, alu_w_d, alu_x_q, alu_x_d, alu_y_q, alu_y_d, alu_z_q, alu_z_d;
  logic [1:0]        op_q, op_d;
  logic              zc_q, zc_d, sc_q, sc_d;
  logic [1:0]        cin1_q, cin1_d;
  logic              cin2_q, cin2_d;

  logic              use_w, use_y, sub, sc, logic_op;
  logic [1:0]        op;
  logic [TOTAL-1:0]  w_full, y_full;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    w_d     = w_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    res_d   = res_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    alu_w_d = alu_w_q;
    alu_x_d = alu_x_q;
    alu_y_d = alu_y_q;
    alu_z_d = alu_z_q;
    op_d    = op_q;
    zc_d    = zc_q;
    sc_d    = sc_q;
    cin1_d  = cin1_q;
    cin2_d  = cin2_q;
    use_w   = 1'b0;
    use_y   = 1'b0;
    sub     = 1'b0;
    sc      = 1'b0;
    op      = 2'b00;
    w_full  = '0;
    y_full  = '0;
    logic_op = (op_q != 2'b00);

    case (in_opcode)
      3'd1:    sub = 1'b1;
      3'd2:    begin use_w = 1'b1; use_y = 1'b1; end
      3'd3:    begin use_y = 1'b1; op = 2'b01; end
      3'd4:    op = 2'b10;
      3'd5:    op = 2'b11;
      3'd6:    begin op = 2'b10; sc = 1'b1; end
      3'd7:    begin op = 2'b11; sc = 1'b1; end
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ISSUE;
          k_d     = '0;
          c1_d    = 2'b00;
          c2_d    = 1'b0;
          w_full  = use_w ? in_W : '0;
          y_full  = use_y ? in_Y : '0;
          // Slice 0 goes straight onto the ALU; the registers keep the remaining slices.
          alu_w_d = w_full[Width-1:0];
          alu_x_d = in_X[Width-1:0];
          alu_y_d = y_full[Width-1:0];
          alu_z_d = in_Z[Width-1:0];
          w_d     = w_full >> Width;
          x_d     = in_X >> Width;
          y_d     = y_full >> Width;
          z_d     = in_Z >> Width;
          op_d    = op;
          zc_d    = sub;
          sc_d    = sc;
          cin1_d  = 2'b00;
          cin2_d  = sub;
        end
      end
      ISSUE: begin
        for (int i = 0; i < SLICES; i++) begin
          if (k_q == KW'(i)) res_d[i*Width +: Width] = alu_S;
        end
        // Logic ops produce no meaningful carries; keep them out of the chain and the report.
        c1_d = logic_op ? 2'b00 : alu_COUT_W_X_Y_CIN;
        c2_d = logic_op ? 1'b0  : alu_COUT_Z_W_X_Y_CIN;
        if (k_q == KW'(SLICES - 1)) begin
          state_d = DONE;
          alu_w_d = '0;
          alu_x_d = '0;
          alu_y_d = '0;
          alu_z_d = '0;
          op_d    = 2'b00;
          zc_d    = 1'b0;
          sc_d    = 1'b0;
          cin1_d  = 2'b00;
          cin2_d  = 1'b0;
        end else begin
          k_d     = k_q + KW'(1);
          alu_w_d = w_q[Width-1:0];
          alu_x_d = x_q[Width-1:0];
          alu_y_d = y_q[Width-1:0];
          alu_z_d = z_q[Width-1:0];
          w_d     = w_q >> Width;
          x_d     = x_q >> Width;
          y_d     = y_q >> Width;
          z_d     = z_q >> Width;
          cin1_d  = c1_d;
          cin2_d  = c2_d;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      w_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      res_q   <= '0;
      c1_q    <= 2'b00;
      c2_q    <= 1'b0;
      alu_w_q <= '0;
      alu_x_q <= '0;
      alu_y_q <= '0;
      alu_z_q <= '0;
      op_q    <= 2'b00;
      zc_q    <= 1'b0;
      sc_q    <= 1'b0;
      cin1_q  <= 2'b00;
      cin2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      w_q     <= w_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      res_q   <= res_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      alu_w_q <= alu_w_d;
      alu_x_q <= alu_x_d;
      alu_y_q <= alu_y_d;
      alu_z_q <= alu_z_d;
      op_q    <= op_d;
      zc_q    <= zc_d;
      sc_q    <= sc_d;
      cin1_q  <= cin1_d;
      cin2_q  <= cin2_d;
    end
  end

  assign in_ready             = (state_q == IDLE);
  assign out_valid            = (state_q == DONE);
  assign out_result           = res_q;
  assign out_carry            = {c1_q, c2_q};
  assign alu_W                = alu_w_q;
  assign alu_X                = alu_x_q;
  assign alu_Y                = alu_y_q;
  assign alu_Z                = alu_z_q;
  assign alu_op               = op_q;
  assign alu_Z_controller     = zc_q;
  assign alu_S_controller     = sc_q;
  assign alu_W_X_Y_controller = 1'b0;
  assign alu_CIN_W_X_Y_CIN    = cin1_q;
  assign alu_CIN_Z_W_X_Y_CIN  = cin2_q;

endmodule

// File: tb/tb_alu_wide_op_sequencer.sv
// Bench for alu_wide_op_sequencer: behavioural ALU slice plus a whole-word arithmetic reference.
module tb_alu_wide_op_sequencer;

  localparam int WD = 8;
  localparam int NS = 4;
  localparam int T  = WD * NS;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_opcode;
  logic [T-1:0]  in_W, in_X, in_Y, in_Z;
  logic [WD-1:0] alu_W, alu_X, alu_Y, alu_Z;
  logic [1:0]    alu_op;
  logic          alu_Z_controller, alu_S_controller, alu_W_X_Y_controller;
  logic [1:0]    alu_CIN_W_X_Y_CIN;
  logic          alu_CIN_Z_W_X_Y_CIN;
  logic [WD-1:0] alu_S;
  logic [1:0]    alu_COUT_W_X_Y_CIN;
  logic          alu_COUT_Z_W_X_Y_CIN;
  logic          out_valid;
  logic          out_ready;
  logic [T-1:0]  out_result;
  logic [2:0]    out_carry;

  int total = 0;
  int bad   = 0;
  logic [2:0] junk = 3'b000;

  always #5 clk = ~clk;

  alu_wide_op_sequencer #(.Width(WD), .SLICES(NS)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_W(in_W), .in_X(in_X), .in_Y(in_Y), .in_Z(in_Z),
    .alu_W(alu_W), .alu_X(alu_X), .alu_Y(alu_Y), .alu_Z(alu_Z),
    .alu_op(alu_op), .alu_Z_controller(alu_Z_controller),
    .alu_S_controller(alu_S_controller), .alu_W_X_Y_controller(alu_W_X_Y_controller),
    .alu_CIN_W_X_Y_CIN(alu_CIN_W_X_Y_CIN), .alu_CIN_Z_W_X_Y_CIN(alu_CIN_Z_W_X_Y_CIN),
    .alu_S(alu_S), .alu_COUT_W_X_Y_CIN(alu_COUT_W_X_Y_CIN),
    .alu_COUT_Z_W_X_Y_CIN(alu_COUT_Z_W_X_Y_CIN),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry)
  );

  // Carry-outs of logic ops are meaningless, so the model returns noise there.
  always @(negedge clk) junk <= 3'($urandom);

  // Behavioural ALU slice.
  always_comb begin
    logic [WD-1:0] zeff, s;
    logic [9:0]    t1;
    logic [8:0]    t2;
    zeff = alu_Z_controller ? ~alu_Z : alu_Z;
    t1 = {2'b00, alu_W} + {2'b00, alu_X} + {2'b00, alu_Y} + {8'd0, alu_CIN_W_X_Y_CIN};
    t2 = {1'b0, zeff} + {1'b0, t1[7:0]} + {8'd0, alu_CIN_Z_W_X_Y_CIN};
    s = t2[7:0];
    alu_COUT_W_X_Y_CIN   = t1[9:8];
    alu_COUT_Z_W_X_Y_CIN = t2[8];
    case (alu_op)
      2'b01: s = alu_W ^ alu_X ^ alu_Y ^ zeff;
      2'b10: s = alu_X & zeff;
      2'b11: s = alu_X | zeff;
      default: ;
    endcase
    if (alu_op != 2'b00) begin
      alu_COUT_W_X_Y_CIN   = junk[2:1];
      alu_COUT_Z_W_X_Y_CIN = junk[0];
    end
    alu_S = alu_S_controller ? ~s : s;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole-word reference: {out_carry, out_result}.
  function automatic logic [34:0] ref_op(input logic [2:0] op, input logic [31:0] w, x, y, z);
    logic [33:0] s1;
    logic [32:0] s2;
    logic [31:0] r;
    logic [2:0]  c;
    c = 3'b000;
    r = '0;
    case (op)
      3'd0: begin s2 = {1'b0, x} + {1'b0, z}; r = s2[31:0]; c = {2'b00, s2[32]}; end
      3'd1: begin s2 = {1'b0, x} + {1'b0, ~z} + 33'd1; r = s2[31:0]; c = {2'b00, s2[32]}; end
      3'd2: begin
        s1 = {2'b00, w} + {2'b00, x} + {2'b00, y};
        s2 = {1'b0, s1[31:0]} + {1'b0, z};
        r  = s2[31:0];
        c  = {s1[33:32], s2[32]};
      end
      3'd3: r = x ^ y ^ z;
      3'd4: r = x & z;
      3'd5: r = x | z;
      3'd6: r = ~(x & z);
      default: r = ~(x | z);
    endcase
    return {c, r};
  endfunction

  function automatic logic [1:0] exp_aluop(input logic [2:0] op);
    case (op)
      3'd3:       return 2'b01;
      3'd4, 3'd6: return 2'b10;
      3'd5, 3'd7: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // Presents a request and returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] w, x, y, z);
    int n;
    @(negedge clk);
    in_opcode = op; in_W = w; in_X = x; in_Y = y; in_Z = z;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge; checks slices, latency, result, and drains it.
  task automatic collect(input logic [2:0] op, input logic [31:0] w, x, y, z, input bit rnd_bp);
    int lat;
    logic [34:0] exp;
    logic [31:0] xs;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat < NS) begin
        xs = x >> (WD * lat);
        chk("alu_x_slice", alu_X, xs[7:0]);
      end
      if (lat == 0) chk("alu_op", alu_op, exp_aluop(op));
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, NS);
    exp = ref_op(op, w, x, y, z);
    chk("result", out_result, exp[31:0]);
    chk("carry", out_carry, exp[34:32]);
    if (rnd_bp) repeat ($urandom_range(0, 2)) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("in_ready_after_hs", in_ready, 1'b1);
    chk("out_valid_after_hs", out_valid, 1'b0);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] w, x, y, z, input bit rnd_bp);
    issue(op, w, x, y, z);
    collect(op, w, x, y, z, rnd_bp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, viol;
    logic [2:0]  op;
    logic [31:0] w, x, y, z;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_opcode = '0;
    in_W = '0; in_X = '0; in_Y = '0; in_Z = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_carry", out_carry, 3'd0);
    chk("rst_alu_ops", {alu_W, alu_X, alu_Y, alu_Z}, 32'd0);
    chk("rst_alu_ctl", {alu_op, alu_Z_controller, alu_S_controller, alu_W_X_Y_controller,
                        alu_CIN_W_X_Y_CIN, alu_CIN_Z_W_X_Y_CIN}, 8'd0);
    reset = 1'b0;

    // Directed cases with hand-known answers.
    run(3'd0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h00000001, 1'b0);
    chk("add_wrap_result", out_result, 32'h00000000);
    chk("add_wrap_carry", out_carry, 3'b001);
    run(3'd1, 32'h0, 32'h00000000, 32'h0, 32'h00000001, 1'b0);
    chk("sub_borrow_result", out_result, 32'hFFFFFFFF);
    chk("sub_borrow_carry", out_carry, 3'b000);
    run(3'd1, 32'h0, 32'd5, 32'h0, 32'd3, 1'b0);
    chk("sub_result", out_result, 32'h00000002);
    chk("sub_carry", out_carry, 3'b001);
    run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("add4_result", out_result, 32'hFFFFFFFC);
    chk("add4_carry", out_carry, 3'b101);
    run(3'd7, 32'h0, 32'hF0F0F0F0, 32'h0, 32'h0F0F00FF, 1'b0);
    chk("nor_result", out_result, 32'h00000F00);
    chk("nor_carry", out_carry, 3'b000);
    run(3'd3, 32'hDEADBEEF, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00FF00FF, 1'b0);
    chk("xor3_result", out_result, 32'hF0F0F0F0);

    // Backpressure: result held, new request waits for the output handshake.
    issue(3'd0, 32'h0, 32'h11111111, 32'h0, 32'h22222222);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_latency", lat, NS);
    in_opcode = 3'd2; in_W = 32'h01010101; in_X = 32'h02020202; in_Y = 32'h03030303;
    in_Z = 32'h04040404; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_result", out_result, 32'h33333333);
      chk("bp_carry", out_carry, 3'b000);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_in_ready_after", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accepted", in_ready, 1'b0);
    collect(3'd2, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 1'b0);

    // Reset while slice 2 is on the ALU.
    issue(3'd0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h00000001);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_alu_ops", {alu_W, alu_X, alu_Y, alu_Z}, 32'd0);
    chk("abort_alu_ctl", {alu_op, alu_Z_controller, alu_S_controller,
                          alu_CIN_W_X_Y_CIN, alu_CIN_Z_W_X_Y_CIN}, 7'd0);
    chk("abort_carry", out_carry, 3'd0);
    viol = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) viol++;
    end
    chk("abort_no_valid", viol, 0);
    run(3'd0, 32'h0, 32'h01020304, 32'h0, 32'h10203040, 1'b0);
    chk("post_abort_add", out_result, 32'h11223344);

    // Randomized operations against the reference.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      w = $urandom; x = $urandom; y = $urandom; z = $urandom;
      if (i % 8 == 0) begin x = 32'hFFFFFFFF; z = $urandom_range(0, 3); end
      run(op, w, x, y, z, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
